keycode_voice_alloc: RTL and testbench

Polyphonic voice allocator directly downstream of the synthesizer SoC's 8-bit `keycode_export` PIO. It turns keycode value changes written by the Nios II MIDI software into note-on, note-off and panic events. It assigns each note to one of `NUM_VOICES` oscillator voices, using the lowest free voice first and least-recently-assigned stealing when all voices are busy. It drives per-voice note number, gate and one-cycle trigger to the oscillator/envelope bank.

---
 rtl/keycode_voice_alloc.sv | 148 ++++++++++++++
 tb/tb_keycode_voice_alloc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/keycode_voice_alloc.sv
// Polyphonic voice allocator: turns keycode changes into note-on/off/panic events and
// assigns notes to voices, lowest free voice first, otherwise the least-recently-assigned.
module keycode_voice_alloc #(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                keycode,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic                      busy
);

    localparam int unsigned RankW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {StIdle, StSearch, StApply} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              kc_q, kc_d;
    logic [7:0]              kc_last_q, kc_last_d;
    logic [7:0]              ev_q, ev_d;
    logic [6:0]              note_q [NUM_VOICES];
    logic [6:0]              note_d [NUM_VOICES];
    logic [RankW-1:0]        rank_q [NUM_VOICES];
    logic [RankW-1:0]        rank_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   gate_q, gate_d;
    logic [NUM_VOICES-1:0]   trig_q, trig_d;
    logic [RankW-1:0]        tgt_q, tgt_d;
    logic                    tgt_vld_q, tgt_vld_d;

    logic                    match_found, free_found;
    logic [RankW-1:0]        match_idx, free_idx, oldest_idx;

    // Descending scan so the lowest qualifying voice wins.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        oldest_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (note_q[i] == ev_q[6:0])) begin
                match_found = 1'b1;
                match_idx   = RankW'(i);
            end
            if (!gate_q[i]) begin
                free_found = 1'b1;
                free_idx   = RankW'(i);
            end
            if (rank_q[i] == RankW'(NUM_VOICES - 1)) begin
                oldest_idx = RankW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        kc_d      = keycode;
        kc_last_d = kc_last_q;
        ev_d      = ev_q;
        note_d    = note_q;
        rank_d    = rank_q;
        gate_d    = gate_q;
        trig_d    = '0;
        tgt_d     = tgt_q;
        tgt_vld_d = tgt_vld_q;
        unique case (state_q)
            StIdle: begin
                if (kc_q != kc_last_q) begin
                    ev_d      = kc_q;
                    kc_last_d = kc_q;
                    state_d   = StSearch;
                end
            end
            StSearch: begin
                // Note-off only needs a match; note-on always resolves to some voice.
                tgt_vld_d = match_found;
                if (match_found) begin
                    tgt_d = match_idx;
                end else if (free_found) begin
                    tgt_d = free_idx;
                end else begin
                    tgt_d = oldest_idx;
                end
                state_d = StApply;
            end
            StApply: begin
                state_d = StIdle;
                if (ev_q == 8'h00) begin
                    gate_d = '0;
                end else if (!ev_q[7]) begin
                    if (tgt_vld_q) begin
                        gate_d[tgt_q] = 1'b0;
                    end
                end else begin
                    note_d[tgt_q] = ev_q[6:0];
                    gate_d[tgt_q] = 1'b1;
                    trig_d[tgt_q] = 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (rank_q[i] < rank_q[tgt_q]) begin
                            rank_d[i] = rank_q[i] + RankW'(1);
                        end
                    end
                    rank_d[tgt_q] = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            kc_q      <= 8'h00;
            kc_last_q <= 8'h00;
            ev_q      <= 8'h00;
            gate_q    <= '0;
            trig_q    <= '0;
            tgt_q     <= '0;
            tgt_vld_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                rank_q[i] <= RankW'(i);
            end
        end else begin
            state_q   <= state_d;
            kc_q      <= kc_d;
            kc_last_q <= kc_last_d;
            ev_q      <= ev_d;
            gate_q    <= gate_d;
            trig_q    <= trig_d;
            tgt_q     <= tgt_d;
            tgt_vld_q <= tgt_vld_d;
            note_q    <= note_d;
            rank_q    <= rank_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : gen_note_out
        assign voice_note[7*g +: 7] = note_q[g];
    end

    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_keycode_voice_alloc.sv
// Randomized and directed bench for keycode_voice_alloc against an event-level reference model
// that keeps voice recency as an ordered list of voice indices.
module tb_keycode_voice_alloc;

    localparam int NV = 4;

    logic              clk;
    logic              reset;
    logic [7:0]        keycode;
    logic [7*NV-1:0]   voice_note;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_trig;
    logic              busy;

    keycode_voice_alloc #(.NUM_VOICES(NV)) dut (
        .clk        (clk),
        .reset      (reset),
        .keycode    (keycode),
        .voice_note (voice_note),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled keycode, last event, pending-event delay, voices, recency list.
    logic [7:0] m_kcq, m_last, m_ev;
    int         m_wait;
    logic [6:0] m_note [NV];
    logic [NV-1:0] m_gate, m_trig;
    int         m_lru[$];   // front = most recently assigned voice

    function automatic logic [7*NV-1:0] m_notes_packed();
        logic [7*NV-1:0] p;
        for (int i = 0; i < NV; i++) p[7*i +: 7] = m_note[i];
        return p;
    endfunction

    task automatic model_reset();
        m_kcq  = 8'h00;
        m_last = 8'h00;
        m_ev   = 8'h00;
        m_wait = 0;
        m_gate = '0;
        m_trig = '0;
        m_lru  = {};
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_lru.push_back(i);
        end
    endtask

    task automatic model_apply();
        int match, free, t, pos;
        match = -1;
        free  = -1;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m_gate[i] && m_note[i] == m_ev[6:0]) match = i;
            if (!m_gate[i]) free = i;
        end
        if (m_ev == 8'h00) begin
            m_gate = '0;
        end else if (!m_ev[7]) begin
            if (match >= 0) m_gate[match] = 1'b0;
        end else begin
            t = (match >= 0) ? match : (free >= 0) ? free : m_lru[m_lru.size() - 1];
            m_note[t] = m_ev[6:0];
            m_gate[t] = 1'b1;
            m_trig[t] = 1'b1;
            pos = 0;
            for (int k = 0; k < m_lru.size(); k++) if (m_lru[k] == t) pos = k;
            m_lru.delete(pos);
            m_lru.push_front(t);
        end
    endtask

    // One clock edge: keycode sampling plus a fixed two-edge delay from latch to apply.
    task automatic model_edge(input logic [7:0] kc_in);
        m_trig = '0;
        if (m_wait == 2) begin
            m_wait = 1;
        end else if (m_wait == 1) begin
            model_apply();
            m_wait = 0;
        end else if (m_kcq != m_last) begin
            m_ev   = m_kcq;
            m_last = m_kcq;
            m_wait = 2;
        end
        m_kcq = kc_in;
    endtask

    task automatic compare_all(input string where);
        check_eq({where, "_note"}, 32'(voice_note), 32'(m_notes_packed()));
        check_eq({where, "_gate"}, 32'(voice_gate), 32'(m_gate));
        check_eq({where, "_trig"}, 32'(voice_trig), 32'(m_trig));
        check_eq({where, "_busy"}, 32'(busy), 32'(m_wait != 0));
    endtask

    // Drive keycode for one cycle; outputs checked on the falling edge.
    task automatic step(input logic [7:0] kc);
        keycode = kc;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(kc);
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic hold(input logic [7:0] kc, input int n);
        for (int i = 0; i < n; i++) step(kc);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic async_reset(input logic [7:0] kc);
        keycode = kc;
        reset   = 1'b1;
        #1;
        model_reset();
        check_eq("rst_gate", 32'(voice_gate), 32'h0);
        check_eq("rst_trig", 32'(voice_trig), 32'h0);
        check_eq("rst_note", 32'(voice_note), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        hold(kc, 2);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        keycode = 8'h00;
        model_reset();
        @(negedge clk);
        async_reset(8'hBC);

        // Reprocessing of a held keycode after reset release.
        hold(8'hBC, 3);
        check_eq("rel_trig_pre", 32'(voice_trig), 32'h0);
        step(8'hBC);
        check_eq("rel_note0", 32'(voice_note[6:0]), 32'd60);
        check_eq("rel_trig", 32'(voice_trig), 32'h1);
        step(8'hBC);
        check_eq("rel_trig_off", 32'(voice_trig), 32'h0);

        // Fill, then steal the oldest voice.
        hold(8'hBE, 4);
        hold(8'hC0, 4);
        hold(8'hC1, 4);
        check_eq("fill_gate", 32'(voice_gate), 32'hF);
        hold(8'hC3, 3);
        step(8'hC3);
        check_eq("steal_trig", 32'(voice_trig), 32'h1);
        check_eq("steal_note0", 32'(voice_note[6:0]), 32'd67);

        // Retrigger voice1, then the next steal moves past it.
        hold(8'hC0, 4);
        hold(8'hBE, 3);
        step(8'hBE);
        check_eq("retrig_trig", 32'(voice_trig), 32'h2);
        hold(8'hC5, 4);

        // Note-off, inactive note-off, then reuse of the freed voice.
        hold(8'h3E, 4);
        hold(8'h46, 4);
        hold(8'hC6, 4);
        hold(8'h00, 4);
        check_eq("panic_gate", 32'(voice_gate), 32'h0);

        // Coalescing: several writes while busy, only the settled value survives.
        step(8'hBC);
        step(8'hBE);
        step(8'hC1);
        hold(8'hC3, 6);

        // Reset while an event is in flight.
        hold(8'hC4, 3);
        async_reset(8'hC4);
        hold(8'hC4, 6);

        for (int it = 0; it < 400; it++) begin
            logic [7:0] kc;
            if ($urandom_range(0, 11) == 0) kc = 8'h00;
            else kc = {1'($urandom_range(0, 2) != 0), 7'(60 + $urandom_range(0, 7))};
            if ($urandom_range(0, 60) == 0) async_reset(kc);
            hold(kc, $urandom_range(1, 5));
        end
        hold(8'h00, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
